// File: rtl/fft_ctrl2048_pkg.sv
// Shared constants and FSM state type for the 2048-point FFT controller.
package fft_ctrl2048_pkg;

    localparam int N            = 2048;
    localparam int LOG2N        = 11;
    localparam int BF_PER_STAGE = 1024;
    localparam int NUM_STAGES   = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RD,
        S_WAIT,
        S_WR,
        S_UNLOAD,
        S_DRAIN
    } state_e;

endpackage

// File: rtl/fft_rdvalid_pipe.sv
// Delays the UNLOAD read-issue strobe by the memory read latency to mark returning data.
module fft_rdvalid_pipe #(
    parameter int MEM_RD_LAT = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic issue_i,
    output logic valid_o
);

    logic [MEM_RD_LAT-1:0] sr_q;

    if (MEM_RD_LAT == 1) begin : g_one
        always_ff @(posedge clock) begin
            if (reset) sr_q <= '0;
            else       sr_q <= issue_i;
        end
    end else begin : g_multi
        always_ff @(posedge clock) begin
            if (reset) sr_q <= '0;
            else       sr_q <= {sr_q[MEM_RD_LAT-2:0], issue_i};
        end
    end

    assign valid_o = sr_q[MEM_RD_LAT-1];

endmodule

// File: rtl/fft_ctrl2048.sv
// Sequencing controller for an in-place radix-2 2048-point FFT: load, 11 butterfly stages, unload.
module fft_ctrl2048
    import fft_ctrl2048_pkg::*;
#(
    parameter int BF_LAT     = 3,
    parameter int MEM_RD_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [10:0] load_addr,
    output logic        load_we,
    output logic        addr_clear,
    output logic        addr_enable,
    output logic        addr_writemode,
    output logic        bf_start,
    output logic        mem_sel,
    output logic [10:0] rd_addr,
    output logic        out_valid,
    output logic [3:0]  stage,
    output logic        busy,
    output logic        done
);

    localparam int                WAIT_CYC   = MEM_RD_LAT + BF_LAT;
    localparam logic [4:0]        WAIT_LAST  = 5'(WAIT_CYC - 1);
    localparam logic [1:0]        DRAIN_LAST = 2'(MEM_RD_LAT - 1);
    localparam logic [3:0]        LAST_STAGE = 4'(NUM_STAGES - 1);
    localparam logic [9:0]        LAST_BF    = 10'(BF_PER_STAGE - 1);
    localparam logic [LOG2N-1:0]  LAST_ADDR  = LOG2N'(N - 1);

    state_e           state_q, state_d;
    logic [LOG2N-1:0] load_cnt_q, load_cnt_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic [9:0]       bf_cnt_q, bf_cnt_d;
    logic [3:0]       stage_q, stage_d;
    logic [4:0]       wait_q, wait_d;
    logic [1:0]       drain_q, drain_d;

    logic in_ready_q, addr_clear_q, addr_enable_q, addr_wm_q;
    logic bf_start_q, mem_sel_q, busy_q, done_q;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        bf_cnt_d   = bf_cnt_q;
        stage_d    = stage_q;
        wait_d     = wait_q;
        drain_d    = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_LOAD;
                    load_cnt_d = '0;
                    rd_cnt_d   = '0;
                    bf_cnt_d   = '0;
                    stage_d    = '0;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (load_cnt_q == LAST_ADDR) state_d = S_RD;
                end
            end
            S_RD: begin
                state_d = S_WAIT;
                wait_d  = WAIT_LAST;
            end
            S_WAIT: begin
                if (wait_q == '0) state_d = S_WR;
                else              wait_d  = wait_q - 1'b1;
            end
            S_WR: begin
                // Butterfly counter wraps naturally at 1024; stage advances on the wrap.
                bf_cnt_d = bf_cnt_q + 1'b1;
                state_d  = S_RD;
                if (bf_cnt_q == LAST_BF) begin
                    if (stage_q == LAST_STAGE) begin
                        state_d = S_UNLOAD;
                        stage_d = '0;
                    end else begin
                        stage_d = stage_q + 1'b1;
                    end
                end
            end
            S_UNLOAD: begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                if (rd_cnt_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = S_IDLE;
                else                       drain_d = drain_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one is aligned with its state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            load_cnt_q    <= '0;
            rd_cnt_q      <= '0;
            bf_cnt_q      <= '0;
            stage_q       <= '0;
            wait_q        <= '0;
            drain_q       <= '0;
            in_ready_q    <= 1'b0;
            addr_clear_q  <= 1'b0;
            addr_enable_q <= 1'b0;
            addr_wm_q     <= 1'b0;
            bf_start_q    <= 1'b0;
            mem_sel_q     <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_cnt_q    <= load_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            bf_cnt_q      <= bf_cnt_d;
            stage_q       <= stage_d;
            wait_q        <= wait_d;
            drain_q       <= drain_d;
            in_ready_q    <= (state_d == S_LOAD);
            addr_clear_q  <= (state_q == S_IDLE) && (state_d == S_LOAD);
            addr_enable_q <= (state_d == S_WR);
            addr_wm_q     <= (state_d == S_WR);
            bf_start_q    <= (state_d == S_RD);
            mem_sel_q     <= (state_d == S_RD) || (state_d == S_WAIT) || (state_d == S_WR);
            busy_q        <= (state_d != S_IDLE);
            done_q        <= (state_d == S_DRAIN) && (drain_d == DRAIN_LAST);
        end
    end

    fft_rdvalid_pipe #(
        .MEM_RD_LAT(MEM_RD_LAT)
    ) u_rdvalid (
        .clock  (clock),
        .reset  (reset),
        .issue_i(state_q == S_UNLOAD),
        .valid_o(out_valid)
    );

    assign in_ready       = in_ready_q;
    assign load_we        = in_ready_q & in_valid;
    assign load_addr      = load_cnt_q;
    assign addr_clear     = addr_clear_q;
    assign addr_enable    = addr_enable_q;
    assign addr_writemode = addr_wm_q;
    assign bf_start       = bf_start_q;
    assign mem_sel        = mem_sel_q;
    assign rd_addr        = rd_cnt_q;
    assign stage          = stage_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_fft_ctrl2048.sv
// Scoreboard bench: a timestamp model predicts every strobe; a negedge monitor consumes them.
module tb_fft_ctrl2048;

    localparam int BF_LAT     = 1;
    localparam int MEM_RD_LAT = 2;
    localparam int P          = 2 + MEM_RD_LAT + BF_LAT;
    localparam int NBF        = 11 * 1024;
    localparam int ABORT_BF   = 3 * 1024 + 5;

    logic        clock = 1'b0;
    logic        reset, start, in_valid;
    logic        in_ready, load_we, addr_clear, addr_enable, addr_writemode;
    logic        bf_start, mem_sel, out_valid, busy, done;
    logic [10:0] load_addr, rd_addr;
    logic [3:0]  stage;

    fft_ctrl2048 #(.BF_LAT(BF_LAT), .MEM_RD_LAT(MEM_RD_LAT)) dut (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .load_addr(load_addr), .load_we(load_we),
        .addr_clear(addr_clear), .addr_enable(addr_enable),
        .addr_writemode(addr_writemode), .bf_start(bf_start), .mem_sel(mem_sel),
        .rd_addr(rd_addr), .out_valid(out_valid), .stage(stage), .busy(busy),
        .done(done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct { int c; int v; } ev_t;
    ev_t q_load[$], q_bf[$], q_wr[$], q_out[$];
    int  q_done[$], q_clr[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_load_we"}, int'(load_we), 0);
        chk({tag, "_load_addr"}, int'(load_addr), 0);
        chk({tag, "_addr_clear"}, int'(addr_clear), 0);
        chk({tag, "_addr_enable"}, int'(addr_enable), 0);
        chk({tag, "_addr_wmode"}, int'(addr_writemode), 0);
        chk({tag, "_bf_start"}, int'(bf_start), 0);
        chk({tag, "_mem_sel"}, int'(mem_sel), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_stage"}, int'(stage), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    // Monitor: every strobe must match the next predicted event in its queue.
    logic [10:0] hist [0:3];
    always @(negedge clock) begin
        ev_t e;
        int  d;
        if (mon_en) begin
            for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = rd_addr;
            if (load_we) begin
                if (q_load.size() == 0) chk("load_we_extra", int'(load_we), 0);
                else begin
                    e = q_load.pop_front();
                    chk("load_cycle", cyc, e.c);
                    chk("load_addr", int'(load_addr), e.v);
                end
            end
            if (bf_start) begin
                chk("rd_mem_sel", int'(mem_sel), 1);
                chk("rd_wmode", int'(addr_writemode), 0);
                if (q_bf.size() == 0) chk("bf_start_extra", int'(bf_start), 0);
                else begin
                    e = q_bf.pop_front();
                    chk("bf_start_cycle", cyc, e.c);
                    chk("rd_stage", int'(stage), e.v);
                end
            end
            if (addr_enable) begin
                chk("wr_mem_sel", int'(mem_sel), 1);
                chk("wr_wmode", int'(addr_writemode), 1);
                if (q_wr.size() == 0) chk("addr_enable_extra", int'(addr_enable), 0);
                else begin
                    e = q_wr.pop_front();
                    chk("addr_enable_cycle", cyc, e.c);
                    chk("wr_stage", int'(stage), e.v);
                end
            end
            if (out_valid) begin
                if (q_out.size() == 0) chk("out_valid_extra", int'(out_valid), 0);
                else begin
                    e = q_out.pop_front();
                    chk("out_valid_cycle", cyc, e.c);
                    chk("out_rd_addr", int'(hist[MEM_RD_LAT]), e.v);
                end
            end
            if (done) begin
                if (q_done.size() == 0) chk("done_extra", int'(done), 0);
                else begin
                    d = q_done.pop_front();
                    chk("done_cycle", cyc, d);
                    chk("done_with_out_valid", int'(out_valid), 1);
                end
            end
            if (addr_clear) begin
                if (q_clr.size() == 0) chk("addr_clear_extra", int'(addr_clear), 0);
                else begin
                    d = q_clr.pop_front();
                    chk("addr_clear_cycle", cyc, d);
                end
            end
        end
    end

    always @(posedge clock) begin
        if (cyc > 98000) begin
            $display("FAIL watchdog: cycle %0d exceeded budget %0d", cyc, 98000);
            $fatal(1, "cycle budget exhausted");
        end
    end

    // Model: load accepts follow the bench's own in_valid choices; everything after is fixed timing.
    task automatic run(input bit abort);
        int  s, acc, c, tl, u, a, end_c, rdc;
        bit  v;
        tick();
        start = 1'b1;
        s = cyc;
        q_clr.push_back(s + 1);
        tick();
        start = 1'b0;
        acc = 0;
        c = s + 1;
        while (acc < 2048) begin
            v = ($urandom_range(0, 3) != 0);
            in_valid = v;
            if (v) begin
                q_load.push_back('{c, acc});
                acc++;
            end
            if (acc < 2048) begin
                tick();
                c++;
            end
        end
        tl = c;
        a  = tl + 1 + ABORT_BF * P + 1;
        for (int k = 0; k < NBF; k++) begin
            rdc = tl + 1 + k * P;
            if (!abort || rdc <= a) q_bf.push_back('{rdc, k / 1024});
            if (!abort || rdc + P - 1 <= a) q_wr.push_back('{rdc + P - 1, k / 1024});
        end
        u = tl + 1 + NBF * P;
        if (!abort) begin
            for (int i = 0; i < 2048; i++) q_out.push_back('{u + i + MEM_RD_LAT, i});
            q_done.push_back(u + 2047 + MEM_RD_LAT);
        end
        end_c = abort ? a : (u + 2047 + MEM_RD_LAT);
        while (cyc < end_c) begin
            tick();
            in_valid = ($urandom_range(0, 1) == 1);
            start    = (cyc < end_c - 3) && ($urandom_range(0, 499) == 0);
        end
        start = 1'b0;
        if (abort) begin
            reset = 1'b1;
            @(negedge clock);
            chk("abort_in_wait_mem_sel", int'(mem_sel), 1);
            chk("abort_in_wait_bf_start", int'(bf_start), 0);
            chk("abort_in_wait_stage", int'(stage), 3);
            chk("abort_in_wait_busy", int'(busy), 1);
            tick();
            reset = 1'b0;
            in_valid = 1'b0;
            @(negedge clock);
            check_all_zero("after_abort");
            chk("abort_pending_bf", q_bf.size(), 0);
            chk("abort_pending_wr", q_wr.size(), 0);
            for (int k = 0; k < 5; k++) tick();
        end else begin
            tick();
            in_valid = 1'b0;
            @(negedge clock);
            chk("idle_after_done_busy", int'(busy), 0);
            chk("idle_after_done_stage", int'(stage), 0);
            chk("idle_after_done_out_valid", int'(out_valid), 0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        mon_en   = 1'b1;
        @(negedge clock);
        check_all_zero("reset");
        run(1'b1);
        run(1'b0);
        chk("leftover_load", q_load.size(), 0);
        chk("leftover_bf", q_bf.size(), 0);
        chk("leftover_wr", q_wr.size(), 0);
        chk("leftover_out", q_out.size(), 0);
        chk("leftover_done", q_done.size(), 0);
        chk("leftover_clear", q_clr.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
